key_debounce_pulse: RTL and testbench

Conditions the four raw active-low board pushbuttons (KEY[3:0]) before they reach the RPN calculator core in MyComputer. Per-key processing: 2-flop synchroniser, stable-time debounce FSM, clean level output, and single-cycle press/release strobes. Also emits an encoded press event (valid + index) that the calculator's command decoder consumes directly. Runs on the 50 MHz board clock, one instance at top level.

---
 rtl/key_debounce_pulse.sv | 163 ++++++++++++++++
 tb/tb_key_debounce_pulse.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Pushbutton conditioner: per-key 2-flop synchroniser, stable-time debounce FSM,
// registered level plus one-cycle press/release strobes, and an encoded press event.
module key_debounce_pulse #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int IDX_W           = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic              press_valid,
   output logic [IDX_W-1:0]  press_idx
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [N_KEYS-1:0] sync1_reg;
   logic [N_KEYS-1:0] sync2_reg;
   logic [N_KEYS-1:0] level_next;
   logic [N_KEYS-1:0] press_next;
   logic [N_KEYS-1:0] release_next;
   logic              valid_next;
   logic [IDX_W-1:0]  idx_next;

   logic [N_KEYS-1:0] key_level_reg;
   logic [N_KEYS-1:0] key_press_reg;
   logic [N_KEYS-1:0] key_release_reg;
   logic              press_valid_reg;
   logic [IDX_W-1:0]  press_idx_reg;

   // Idle-high reset value keeps a released key from looking like a press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_reg <= '1;
         sync2_reg <= '1;
      end else begin
         sync1_reg <= key_n;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         state_t           state_reg;
         state_t           state_next;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
            end
         end

         // sync2 low means the key is being held down.
         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
               IDLE: begin
                  if (!sync2_reg[gi]) begin
                     state_next = PRESS_WAIT;
                     cnt_next   = CNT_ONE;
                  end else begin
                     cnt_next   = '0;
                  end
               end
               PRESS_WAIT: begin
                  if (sync2_reg[gi]) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next = HELD;
                     cnt_next   = '0;
                  end else begin
                     cnt_next   = cnt_reg + CNT_ONE;
                  end
               end
               HELD: begin
                  if (sync2_reg[gi]) begin
                     state_next = RELEASE_WAIT;
                     cnt_next   = CNT_ONE;
                  end else begin
                     cnt_next   = '0;
                  end
               end
               RELEASE_WAIT: begin
                  if (!sync2_reg[gi]) begin
                     state_next = HELD;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else begin
                     cnt_next   = cnt_reg + CNT_ONE;
                  end
               end
               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            endcase
         end

         assign level_next[gi] = (state_reg == HELD) || (state_reg == RELEASE_WAIT);
      end
   endgenerate

   // The level only rises on PRESS_WAIT->HELD and only falls on RELEASE_WAIT->IDLE,
   // so its edges are exactly the accepted press/release events.
   assign press_next   = level_next & ~key_level_reg;
   assign release_next = ~level_next & key_level_reg;
   assign valid_next   = |press_next;

   always_comb begin
      idx_next = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (press_next[i]) begin
            idx_next = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_level_reg   <= '0;
         key_press_reg   <= '0;
         key_release_reg <= '0;
         press_valid_reg <= 1'b0;
         press_idx_reg   <= '0;
      end else begin
         key_level_reg   <= level_next;
         key_press_reg   <= press_next;
         key_release_reg <= release_next;
         press_valid_reg <= valid_next;
         press_idx_reg   <= idx_next;
      end
   end

   assign key_level   = key_level_reg;
   assign key_press   = key_press_reg;
   assign key_release = key_release_reg;
   assign press_valid = press_valid_reg;
   assign press_idx   = press_idx_reg;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed and randomized check of key_debounce_pulse against a run-length
// model of the debounce rule (accept a change after D consecutive samples).
module tb_key_debounce_pulse;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_n = 4'hF;
   logic [3:0] key_level;
   logic [3:0] key_press;
   logic [3:0] key_release;
   logic       press_valid;
   logic [1:0] press_idx;

   key_debounce_pulse #(
      .N_KEYS(4),
      .DEBOUNCE_CYCLES(D),
      .CNT_W(20),
      .IDX_W(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_n(key_n),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .press_valid(press_valid),
      .press_idx(press_idx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: raw-sample pipeline, accepted level, run length of
   // samples disagreeing with the accepted level, and expected registered outputs.
   logic [3:0] m_p1 = 4'hF, m_p2 = 4'hF, m_acc = 4'h0;
   logic [3:0] e_level = 4'h0, e_press = 4'h0, e_rel = 4'h0;
   int         m_run [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [3:0] held;
      if (!rst_n) begin
         m_p1 = 4'hF; m_p2 = 4'hF; m_acc = 4'h0;
         e_level = 4'h0; e_press = 4'h0; e_rel = 4'h0;
         for (int k = 0; k < 4; k++) m_run[k] = 0;
      end else begin
         e_press = m_acc & ~e_level;
         e_rel   = ~m_acc & e_level;
         e_level = m_acc;
         held = ~m_p2;
         for (int k = 0; k < 4; k++) begin
            if (held[k] != m_acc[k]) begin
               m_run[k]++;
               if (m_run[k] == D) begin
                  m_acc[k] = ~m_acc[k];
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
         end
         m_p2 = m_p1;
         m_p1 = key_n;
      end
   endtask

   function automatic logic [1:0] lowest(input logic [3:0] v);
      for (int k = 0; k < 4; k++) if (v[k]) return 2'(k);
      return 2'd0;
   endfunction

   task automatic tick(input string ph);
      @(posedge clk);
      model_step();
      #1;
      chk({ph, ".level"},   32'(key_level),   32'(e_level));
      chk({ph, ".press"},   32'(key_press),   32'(e_press));
      chk({ph, ".release"}, 32'(key_release), 32'(e_rel));
      chk({ph, ".valid"},   32'(press_valid), 32'(|e_press));
      chk({ph, ".idx"},     32'(press_idx),   32'(lowest(e_press)));
      $display("[%0t] %s key_n=%b lvl=%b prs=%b rel=%b v=%b idx=%0d",
               $time, ph, key_n, key_level, key_press, key_release, press_valid, press_idx);
   endtask

   int cnt;

   initial begin
      for (int k = 0; k < 4; k++) m_run[k] = 0;

      rst_n = 1'b0; key_n = 4'hF;
      repeat (3) tick("reset");
      rst_n = 1'b1;
      repeat (3) tick("idle");

      // Clean press on key 0
      key_n[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick("press0");
         chk("press0.strobe_at_6", 32'(key_press[0]), 32'(i == 6));
         if (i >= 6) chk("press0.level_held", 32'(key_level[0]), 32'd1);
      end

      // Release of key 0
      key_n[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick("rel0");
         chk("rel0.strobe_at_6", 32'(key_release[0]), 32'(i == 6));
         chk("rel0.no_valid", 32'(press_valid), 32'd0);
      end

      // Bounce on key 1, then a real press
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         key_n[1] = ((i / 2) % 2) != 0;
         tick("bounce1");
         if (key_press[1]) cnt++;
         chk("bounce1.level", 32'(key_level[1]), 32'd0);
      end
      key_n[1] = 1'b1;
      repeat (6) tick("bounce1.quiet");
      key_n[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick("hold1");
         if (key_press[1]) cnt++;
      end
      chk("bounce1.press_count", 32'(cnt), 32'd1);
      key_n[1] = 1'b1;
      repeat (12) tick("rel1");

      // Simultaneous presses of keys 1 and 3
      key_n = 4'b0101;
      for (int i = 0; i < 12; i++) begin
         tick("simul");
         if (i == 6) begin
            chk("simul.press", 32'(key_press), 32'hA);
            chk("simul.idx", 32'(press_idx), 32'd1);
            chk("simul.valid", 32'(press_valid), 32'd1);
         end
      end
      key_n = 4'hF;
      repeat (12) tick("simul.rel");

      // Reset while key 3 is mid-count
      key_n[3] = 1'b0;
      repeat (4) tick("rst3.count");
      rst_n = 1'b0;
      tick("rst3.reset");
      chk("rst3.outputs_zero", 32'({key_level, key_press, key_release, press_valid, press_idx}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick("rst3.after");
         chk("rst3.strobe_at_6", 32'(key_press[3]), 32'(i == 6));
      end
      key_n[3] = 1'b1;
      repeat (12) tick("rst3.rel");

      // Long hold on key 2
      key_n[2] = 1'b0;
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         tick("long2");
         if (key_press[2]) cnt++;
         if (i >= 6 && key_level[2] !== 1'b1) chk("long2.level", 32'(key_level[2]), 32'd1);
      end
      chk("long2.press_count", 32'(cnt), 32'd1);
      key_n[2] = 1'b1;
      repeat (12) tick("long2.rel");

      // Random key activity with occasional resets
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 5) == 0) key_n[k] = ~key_n[k];
         end
         rst_n = ($urandom_range(0, 149) != 0);
         tick("rand");
      end
      rst_n = 1'b1;
      key_n = 4'hF;
      repeat (12) tick("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
